// File: rtl/manager_pkg.sv
// Shared definitions for the RS-232 frame managers: receive FSM states, frame defaults and
// the address/data checksum used by both the transmit and receive sides.
package manager_pkg;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    WAIT_ADDR = 2'd1,
    WAIT_DATA = 2'd2,
    WAIT_CHK  = 2'd3
  } rx_state_e;

  localparam logic [7:0]  DEFAULT_SYNC_BYTE      = 8'hAA;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 50000;

  function automatic logic [7:0] frame_checksum(input logic [7:0] addr, input logic [7:0] data);
    return addr ^ data;
  endfunction

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte idle timer: counts cycles while enabled, restarts on clear, and pulses o_expire
// in the cycle that completes TIMEOUT_CYCLES idle cycles.
module rx_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic CLK_50MHZ,
  input  logic RST,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 1);

  logic [CntW-1:0] r_cnt;

  // A clear in the expiry cycle wins, so a strobe arriving exactly at the deadline is kept.
  assign o_expire = i_enable && !i_clear && (r_cnt == LastCnt);

  always_ff @(posedge CLK_50MHZ) begin
    if (RST || i_clear || !i_enable || o_expire) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/manager_rx_fsm.sv
// Receive-side frame manager: hunts for the sync byte, collects address, data and checksum,
// and publishes validated frames with a one-cycle rx_valid pulse.
module manager_rx_fsm
  import manager_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       CLK_50MHZ,
  input  logic       RST,
  input  logic [7:0] RS_DATAOUT,
  input  logic       RS_TRG_READ,
  output logic [7:0] addr_rx,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  output logic       rx_error,
  output logic       rx_busy,
  output logic [7:0] err_cnt
);

  rx_state_e  r_state;
  rx_state_e  w_state_next;
  logic [7:0] r_addr_buf;
  logic [7:0] r_data_buf;
  logic       w_expire;
  logic       w_chk_ok;
  logic       w_frame_done;
  logic       w_valid_next;
  logic       w_error_next;

  rx_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .CLK_50MHZ(CLK_50MHZ),
    .RST      (RST),
    .i_clear  (RS_TRG_READ),
    .i_enable (r_state != WAIT_SYNC),
    .o_expire (w_expire)
  );

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_state <= WAIT_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      WAIT_SYNC: if (RS_TRG_READ && (RS_DATAOUT == SYNC_BYTE)) w_state_next = WAIT_ADDR;
      WAIT_ADDR: begin
        if (RS_TRG_READ)   w_state_next = WAIT_DATA;
        else if (w_expire) w_state_next = WAIT_SYNC;
      end
      WAIT_DATA: begin
        if (RS_TRG_READ)   w_state_next = WAIT_CHK;
        else if (w_expire) w_state_next = WAIT_SYNC;
      end
      WAIT_CHK:  if (RS_TRG_READ || w_expire) w_state_next = WAIT_SYNC;
      default:   w_state_next = WAIT_SYNC;
    endcase
  end

  always_comb begin
    w_chk_ok     = (RS_DATAOUT == frame_checksum(r_addr_buf, r_data_buf));
    w_frame_done = (r_state == WAIT_CHK) && RS_TRG_READ;
    w_valid_next = w_frame_done && w_chk_ok;
    w_error_next = (w_frame_done && !w_chk_ok) || w_expire;
  end

  always_ff @(posedge CLK_50MHZ) begin
    if (RST) begin
      r_addr_buf <= '0;
      r_data_buf <= '0;
      addr_rx    <= '0;
      data_rx    <= '0;
      rx_valid   <= 1'b0;
      rx_error   <= 1'b0;
      rx_busy    <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if ((r_state == WAIT_ADDR) && RS_TRG_READ) r_addr_buf <= RS_DATAOUT;
      if ((r_state == WAIT_DATA) && RS_TRG_READ) r_data_buf <= RS_DATAOUT;
      if (w_valid_next) begin
        addr_rx <= r_addr_buf;
        data_rx <= r_data_buf;
      end
      rx_valid <= w_valid_next;
      rx_error <= w_error_next;
      rx_busy  <= (w_state_next != WAIT_SYNC);
      if (w_error_next && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_manager_rx_fsm.sv
// Randomised and directed bench for manager_rx_fsm against a timestamped frame-queue model.
module tb_manager_rx_fsm;

  localparam int unsigned Timeout = 16;
  localparam logic [7:0]  Sync    = 8'hAA;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       strb;
  logic [7:0] addr_rx, data_rx, err_cnt;
  logic       rx_valid, rx_error, rx_busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #10 clk = ~clk;

  manager_rx_fsm #(
    .SYNC_BYTE     (Sync),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .CLK_50MHZ  (clk),
    .RST        (rst),
    .RS_DATAOUT (din),
    .RS_TRG_READ(strb),
    .addr_rx    (addr_rx),
    .data_rx    (data_rx),
    .rx_valid   (rx_valid),
    .rx_error   (rx_error),
    .rx_busy    (rx_busy),
    .err_cnt    (err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: bytes of the current frame kept in a queue, timeout from timestamps.
  logic [7:0]  q[$];
  int unsigned cyc = 0;
  int unsigned last_t = 0;
  logic [7:0]  m_addr = 0, m_data = 0, m_errc = 0;
  logic        m_valid = 0, m_error = 0;

  task automatic model_error();
    m_error = 1'b1;
    if (m_errc != 8'd255) m_errc = m_errc + 8'd1;
    q.delete();
  endtask

  always @(posedge clk) begin
    cyc++;
    m_valid = 1'b0;
    m_error = 1'b0;
    if (rst) begin
      q.delete();
      m_addr = 0;
      m_data = 0;
      m_errc = 0;
    end else if (strb) begin
      if (q.size() == 0) begin
        if (din == Sync) begin
          q.push_back(din);
          last_t = cyc;
        end
      end else begin
        q.push_back(din);
        last_t = cyc;
        if (q.size() == 4) begin
          if (q[3] == (q[1] ^ q[2])) begin
            m_valid = 1'b1;
            m_addr  = q[1];
            m_data  = q[2];
            q.delete();
          end else begin
            model_error();
          end
        end
      end
    end else if ((q.size() != 0) && (cyc - last_t >= Timeout)) begin
      model_error();
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
      check("rx_error", {31'd0, rx_error}, {31'd0, m_error});
      check("rx_busy", {31'd0, rx_busy}, {31'd0, (q.size() != 0)});
      check("addr_rx", {24'd0, addr_rx}, {24'd0, m_addr});
      check("data_rx", {24'd0, data_rx}, {24'd0, m_data});
      check("err_cnt", {24'd0, err_cnt}, {24'd0, m_errc});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    idle(gap);
    din  = b;
    strb = 1'b1;
    @(negedge clk);
    strb = 1'b0;
  endtask

  task automatic frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c,
                       input int gap);
    send(Sync, gap);
    send(a, gap);
    send(d, gap);
    send(c, gap);
  endtask

  initial begin
    rst  = 1'b1;
    din  = 8'h00;
    strb = 1'b0;
    idle(3);
    rst    = 1'b0;
    chk_en = 1'b1;
    check("rst_addr", {24'd0, addr_rx}, 32'h0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'h0);
    check("rst_busy", {31'd0, rx_busy}, 32'h0);

    // Good frame, strobes 4 cycles apart; the window after the last strobe holds rx_valid.
    frame(8'h12, 8'h34, 8'h26, 3);
    check("tp1_valid", {31'd0, rx_valid}, 32'h1);
    check("tp1_addr", {24'd0, addr_rx}, 32'h12);
    check("tp1_data", {24'd0, data_rx}, 32'h34);
    idle(4);

    // Bad checksum, then a good frame.
    frame(8'h12, 8'h34, 8'h00, 1);
    check("tp2_error", {31'd0, rx_error}, 32'h1);
    check("tp2_errcnt", {24'd0, err_cnt}, 32'h1);
    check("tp2_addr_kept", {24'd0, addr_rx}, 32'h12);
    idle(2);
    frame(8'h5A, 8'hC3, 8'h99, 0);
    idle(2);

    // Leading garbage.
    send(8'h55, 1);
    send(8'h13, 1);
    frame(8'h01, 8'h02, 8'h03, 1);
    check("tp3_addr", {24'd0, addr_rx}, 32'h01);
    idle(3);

    // Timeout: silence after the address, then a strobe exactly at the deadline.
    send(Sync, 0);
    send(8'h12, 0);
    idle(24);
    send(Sync, 0);
    send(8'h12, 0);
    send(8'h34, Timeout - 1);
    send(8'h26, Timeout - 1);
    check("tp4_deadline_valid", {31'd0, rx_valid}, 32'h1);
    send(Sync, 0);
    send(8'h12, Timeout);
    idle(20);

    // Back-to-back frames.
    frame(8'h0F, 8'hF0, 8'hFF, 0);
    frame(8'h10, 8'h20, 8'h30, 0);
    idle(3);

    // Random traffic: garbage, good/bad checksums, short and over-long gaps.
    for (int i = 0; i < 80; i++) begin
      logic [7:0] a, d, c;
      int gap;
      a = 8'($urandom);
      d = 8'($urandom);
      c = ($urandom_range(0, 3) != 0) ? (a ^ d) : 8'($urandom);
      repeat ($urandom_range(0, 2)) send(8'($urandom), $urandom_range(0, 2));
      for (int k = 0; k < 4; k++) begin
        gap = ($urandom_range(0, 9) == 0) ? $urandom_range(Timeout - 2, Timeout + 2)
                                          : $urandom_range(0, 3);
        send((k == 0) ? Sync : (k == 1) ? a : (k == 2) ? d : c, gap);
      end
    end
    idle(20);

    // Reset in WAIT_DATA drops the frame without a pulse.
    send(Sync, 0);
    send(8'h77, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", {31'd0, rx_busy}, 32'h0);
    check("rst_mid_errcnt", {24'd0, err_cnt}, 32'h0);
    check("rst_mid_addr", {24'd0, addr_rx}, 32'h0);
    idle(2);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) frame(8'h01, 8'h02, 8'h00, 0);
    idle(2);
    check("sat_errcnt", {24'd0, err_cnt}, 32'd255);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
